instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Fetch stage directly upstream of the unified memory. It drives the memory's combinational PC read port and captures the returned 35-bit instruction word together with its PC into a small circular prefetch queue. It presents queue entries to decode over a valid/ready handshake. Branch/jump redirects flush the queue and reload the PC.

Parameters:
INSTR_W, 35, instruction word width (matches memory instruction port)
QUEUE_DEPTH, 4, prefetch queue entries; power of two, >= 2
RESET_PC, 32'h0000_0000, PC value loaded on reset; word-aligned
MEM_TOP_BIT, 13, highest implemented address bit; PC[31:MEM_TOP_BIT+1] must be zero

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
PC  output  32  fetch address to memory instruction port
instruction  input  INSTR_W  word returned combinationally by memory for PC
redirect_en  input  1  load redirect_pc and flush queue this cycle
redirect_pc  input  32  redirect target address
instr_out  output  INSTR_W  head-of-queue instruction
instr_pc_out  output  32  PC of head-of-queue instruction
instr_valid  output  1  head entry valid
instr_ready  input  1  decode accepts head entry when high with instr_valid
misalign_err  output  1  sticky: a redirect target had nonzero [1:0]
range_err  output  1  high while PC is outside implemented memory; fetch halted

Behaviour:
- Reset (async assert, sync-safe deassert): PC=RESET_PC; queue count, head and tail = 0; instr_valid=0; instr_out=0; instr_pc_out=0; misalign_err=0; range_err=0.
- pop = instr_valid & instr_ready. push = !redirect_en & !range_err & (count<QUEUE_DEPTH | pop).
- On push: store {instruction, PC} at tail; tail advances mod QUEUE_DEPTH; PC <= PC+4 (32-bit wrap, carry discarded).
- On pop: head advances mod QUEUE_DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full with simultaneous pop: push proceeds, count stays QUEUE_DEPTH.
- Full without pop: no push; PC holds.
- Empty: instr_valid=0; instr_ready ignored.
- Latency: the word at PC appears on instr_out one cycle after the edge that captures it. First instr_valid is the cycle after the first clock edge following reset release.
- Redirect has priority over push and pop in the same cycle:
  - Head, tail and count are cleared; any pop that cycle is discarded (decode must not treat it as consumed).
  - PC <= {redirect_pc[31:2], 2'b00}.
  - If redirect_pc[1:0] != 0, set misalign_err; it stays set until reset.
- range_err is combinational: |PC[31:MEM_TOP_BIT+1].
  - While range_err=1, no push; already-queued entries still drain normally.
  - Only a redirect or reset clears the condition.
- PC increment reaching 2^(MEM_TOP_BIT+1) raises range_err the next cycle; no wrap to 0.
- instr_out and instr_pc_out always show the head entry. Their value while instr_valid=0 is don't-care, except the reset value of 0.

Optional Feature:
FETCH_BYPASS_EN
- Defined: when the queue is empty, !redirect_en, !range_err and instr_ready=1, the memory word is forwarded combinationally that same cycle.
  - instr_valid=1, instr_out=instruction, instr_pc_out=PC.
  - The word is consumed without being enqueued; PC still advances by 4.
  - Gives zero-latency fetch when decode is never stalled.
- Undefined: no combinational path from instruction to instr_out; latency is 1 cycle as specified above.

Test Plan:
- Reset with RESET_PC=0 and mem[0..3]=A,B,C,D, instr_ready=1 → PC sequence 0,4,8,C; instr_out sequence A,B,C,D starting 1 cycle after reset release, with instr_pc_out 0,4,8,C.
- instr_ready=0 for 6 cycles after reset → count saturates at 4; PC holds at 0x10; instr_out=A. Raise instr_ready → A,B,C,D,E appear on consecutive cycles with no bubble.
- Queue full, redirect_en=1 and instr_ready=1 in the same cycle with redirect_pc=0x40 → next cycle instr_valid=0 and PC=0x40; following cycle instr_out=mem[0x10 word], instr_pc_out=0x40.
- redirect_pc=0x22 → PC=0x20; misalign_err=1 and stays 1 after a later aligned redirect to 0x0.
- Redirect to 0x3FF8 with ready=1 → fetches 0x3FF8 and 0x3FFC; PC=0x4000; range_err=1; no further pushes. Redirect to 0x0 → range_err=0 and fetch resumes.
- Assert reset mid-stream with count=3 → instr_valid=0 and PC=RESET_PC immediately (asynchronous), no clock edge required.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage in front of the unified memory.
// Drives PC to the memory's combinational instruction port, captures
// {instruction, PC} into a circular prefetch queue and hands the head
// entry to decode over a valid/ready handshake.
//
// Handshake: an entry moves to decode on a rising edge where instr_valid
// and instr_ready are both high. instr_valid never depends on instr_ready
// unless the bypass is built in. A redirect in the same cycle wins: the
// queue is flushed and the pop that cycle does not count as consumed.
//
// Optional build macro FETCH_BYPASS_EN: when the queue is empty and decode
// is ready, the memory word is forwarded combinationally in the same cycle
// and is not enqueued. Without the macro there is no combinational path
// from instruction to instr_out.
module instruction_fetch #(
  parameter int          INSTR_W     = 35,
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TOP_BIT = 13
) (
  input  logic               clk,
  input  logic               reset,
  output logic [31:0]        PC,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               redirect_en,
  input  logic [31:0]        redirect_pc,
  output logic [INSTR_W-1:0] instr_out,
  output logic [31:0]        instr_pc_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               misalign_err,
  output logic               range_err
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]        pc_q, pc_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               misalign_q, misalign_d;
  logic [INSTR_W-1:0] ent_instr_q [QUEUE_DEPTH];
  logic [INSTR_W-1:0] ent_instr_d [QUEUE_DEPTH];
  logic [31:0]        ent_pc_q [QUEUE_DEPTH];
  logic [31:0]        ent_pc_d [QUEUE_DEPTH];

  logic empty;
  logic full;
  logic bypass;
  logic pop;
  logic push;
  logic advance;

  // Queue status and the out-of-range halt, all from registered state.
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(QUEUE_DEPTH));
  assign range_err = |pc_q[31:MEM_TOP_BIT+1];

`ifdef FETCH_BYPASS_EN
  assign bypass = empty & ~redirect_en & ~range_err & instr_ready;
`else
  assign bypass = 1'b0;
`endif

  // A queued entry leaves on pop; a bypassed word never enters the queue.
  assign pop     = ~empty & instr_ready;
  assign push    = ~redirect_en & ~range_err & (~full | pop) & ~bypass;
  assign advance = push | bypass;

  assign PC           = pc_q;
  assign misalign_err = misalign_q;

  // Head-of-queue presentation, or the live memory word when bypassing.
  always_comb begin
    instr_valid  = ~empty;
    instr_out    = ent_instr_q[head_q];
    instr_pc_out = ent_pc_q[head_q];
    if (bypass) begin
      instr_valid  = 1'b1;
      instr_out    = instruction;
      instr_pc_out = pc_q;
    end
  end

  // Next-state: redirect flushes and reloads PC, otherwise push/pop update.
  always_comb begin
    pc_d        = pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    misalign_d  = misalign_q;
    ent_instr_d = ent_instr_q;
    ent_pc_d    = ent_pc_q;
    if (redirect_en) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pc_d    = {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else begin
      if (push) begin
        ent_instr_d[tail_q] = instruction;
        ent_pc_d[tail_q]    = pc_q;
        tail_d              = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
      if (advance) begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  // State registers; entries clear on reset so the head reads as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        ent_instr_q[i] <= '0;
        ent_pc_q[i]    <= '0;
      end
    end else begin
      pc_q        <= pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      misalign_q  <= misalign_d;
      ent_instr_q <= ent_instr_d;
      ent_pc_q    <= ent_pc_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch (default build, no bypass).
// A small memory model answers the PC port combinationally.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [34:0] instruction;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [34:0] instr_out;
  logic [31:0] instr_pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        misalign_err;
  logic        range_err;

  int checks;
  int errors;

  instruction_fetch dut (
    .clk          (clk),
    .reset        (rst),
    .PC           (pc),
    .instruction  (instruction),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .instr_out    (instr_out),
    .instr_pc_out (instr_pc_out),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .misalign_err (misalign_err),
    .range_err    (range_err)
  );

  // Clock: 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: a distinct, nonzero word for every address.
  function automatic logic [34:0] mem_word(input logic [31:0] a);
    return {3'b110, a ^ 32'h5A5A_0000};
  endfunction

  always_comb instruction = mem_word(pc);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges, then release it (leaves ready as given).
  task automatic do_reset(input logic ready);
    rst         = 1'b1;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = ready;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_en = 1'b1;
    redirect_pc = target;
    tick();
    redirect_en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b1;

    // Reset values.
    tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_out", instr_out, 0);
    chk("rst_pcout", instr_pc_out, 0);
    chk("rst_misalign", misalign_err, 0);
    chk("rst_range", range_err, 0);

    // Streaming with decode always ready: one-cycle latency, no bubbles.
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("stream_pc_before", pc, 32'(4 * i));
      tick();
      chk("stream_valid", instr_valid, 1);
      chk("stream_out", instr_out, mem_word(32'(4 * i)));
      chk("stream_pcout", instr_pc_out, 32'(4 * i));
    end
    chk("stream_pc_after", pc, 32'h10);

    // Stall: queue fills to four entries, PC holds at 0x10.
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) tick();
    chk("stall_pc", pc, 32'h10);
    chk("stall_valid", instr_valid, 1);
    chk("stall_out", instr_out, mem_word(32'h0));
    instr_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("drain_valid", instr_valid, 1);
      chk("drain_out", instr_out, mem_word(32'(4 * i)));
      chk("drain_pcout", instr_pc_out, 32'(4 * i));
      chk("drain_pc", pc, 32'(16 + 4 * i));
    end

    // Redirect while full and popping: flush wins.
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk("full_pc", pc, 32'h10);
    instr_ready = 1'b1;
    redirect(32'h40);
    chk("redir_valid", instr_valid, 0);
    chk("redir_pc", pc, 32'h40);
    tick();
    chk("redir_first_valid", instr_valid, 1);
    chk("redir_first_out", instr_out, mem_word(32'h40));
    chk("redir_first_pcout", instr_pc_out, 32'h40);

    // Misaligned target is truncated and the error is sticky.
    redirect(32'h22);
    chk("mis_pc", pc, 32'h20);
    chk("mis_flag", misalign_err, 1);
    tick();
    redirect(32'h0);
    chk("mis_aligned_pc", pc, 32'h0);
    chk("mis_sticky", misalign_err, 1);

    // Top of implemented memory: two fetches, then halt without wrapping.
    redirect(32'h3FF8);
    chk("top_pc", pc, 32'h3FF8);
    chk("top_range0", range_err, 0);
    tick();
    chk("top_out0", instr_out, mem_word(32'h3FF8));
    tick();
    chk("top_out1", instr_out, mem_word(32'h3FFC));
    chk("top_pc_end", pc, 32'h4000);
    chk("top_range1", range_err, 1);
    tick();
    chk("top_drained", instr_valid, 0);
    chk("top_pc_hold", pc, 32'h4000);
    tick();
    chk("top_no_push", instr_valid, 0);
    chk("top_range_hold", range_err, 1);
    redirect(32'h0);
    chk("top_range_clr", range_err, 0);
    chk("top_resume_pc", pc, 32'h0);
    tick();
    chk("top_resume_valid", instr_valid, 1);
    chk("top_resume_out", instr_out, mem_word(32'h0));

    // Asynchronous reset mid-stream with three entries queued.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("async_pre_pc", pc, 32'hC);
    chk("async_pre_valid", instr_valid, 1);
    rst = 1'b1;
    #1;
    chk("async_valid", instr_valid, 0);
    chk("async_pc", pc, 32'h0);
    chk("async_misalign", misalign_err, 0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
